// File: rtl/rv_sync_fifo_pkg.sv
// Shared sizing helpers and default thresholds for rv_sync_fifo.
package rv_sync_fifo_pkg;

  localparam int DEF_AFULL_MARGIN  = 1;  // almost_full default sits one below DEPTH
  localparam int DEF_AEMPTY_THRESH = 1;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rv_sync_fifo_if.sv
// Valid/ready producer and consumer bundle plus occupancy status for rv_sync_fifo.
interface rv_sync_fifo_if
  import rv_sync_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CW = cnt_w(DEPTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             almost_full;
  logic             almost_empty;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, almost_full, almost_empty
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, almost_full, almost_empty
  );

endinterface

// File: rtl/rv_sync_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module rv_sync_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rv_sync_fifo.sv
// Synchronous FWFT valid/ready FIFO, 1-cycle write-to-read latency; in_ready drops only when full or flushing.
// Define RV_SYNC_FIFO_BYPASS_EN to pass words straight through while empty (zero latency).
module rv_sync_fifo
  import rv_sync_fifo_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int WIDTH         = 32,
  parameter int AFULL_THRESH  = DEPTH - DEF_AFULL_MARGIN,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input logic          clk,
  input logic          reset,
  input logic          flush,
  rv_sync_fifo_if.slave bus
);

  localparam int CW = cnt_w(DEPTH);
  localparam int AW = ptr_w(DEPTH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("rv_sync_fifo: DEPTH must be >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("rv_sync_fifo: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("rv_sync_fifo: AEMPTY_THRESH must be in 0..DEPTH-1");
  end

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rd_data;
  logic             empty, full, wr_fire, rd_fire, store;

  // Explicit wrap so non-power-of-two depths index correctly.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty        = (cnt == '0);
  assign full         = (cnt == CW'(DEPTH));
  assign bus.in_ready = !full && !flush;
  assign wr_fire      = bus.in_valid && !full && !flush;

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    rd_fire       = 1'b0;
    store         = wr_fire;
`ifdef RV_SYNC_FIFO_BYPASS_EN
    if (empty && !flush) begin
      bus.out_valid = bus.in_valid;
      bus.out_data  = bus.in_data;
      // A word taken on the same cycle never touches storage.
      store         = wr_fire && !bus.out_ready;
    end else if (!empty && !flush) begin
      bus.out_valid = 1'b1;
      bus.out_data  = rd_data;
      rd_fire       = bus.out_ready;
    end
`else
    if (!empty && !flush) begin
      bus.out_valid = 1'b1;
      bus.out_data  = rd_data;
      rd_fire       = bus.out_ready;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (store)   wr_ptr <= ptr_inc(wr_ptr);
      if (rd_fire) rd_ptr <= ptr_inc(rd_ptr);
      case ({store, rd_fire})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  rv_sync_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (store),
    .waddr (wr_ptr),
    .wdata (bus.in_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign bus.count        = cnt;
  assign bus.almost_full  = (cnt >= CW'(AFULL_THRESH));
  assign bus.almost_empty = (cnt <= CW'(AEMPTY_THRESH));

endmodule

// File: tb/tb_rv_sync_fifo.sv
// Directed bench for rv_sync_fifo at DEPTH=5, WIDTH=8, AFULL_THRESH=4, AEMPTY_THRESH=1.
module tb_rv_sync_fifo;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rv_sync_fifo_if #(.WIDTH(8), .DEPTH(5)) bus ();

  rv_sync_fifo #(
    .DEPTH         (5),
    .WIDTH         (8),
    .AFULL_THRESH  (4),
    .AEMPTY_THRESH (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    logic       fl;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [2:0] e_cnt;
    logic       e_af;
    logic       e_ae;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic ir, input logic ov, input logic [7:0] od,
                             input logic [2:0] c, input logic af, input logic ae);
    chk({tag, ".in_ready"},     32'(bus.in_ready),     32'(ir));
    chk({tag, ".out_valid"},    32'(bus.out_valid),    32'(ov));
    chk({tag, ".out_data"},     32'(bus.out_data),     32'(od));
    chk({tag, ".count"},        32'(bus.count),        32'(c));
    chk({tag, ".almost_full"},  32'(bus.almost_full),  32'(af));
    chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(ae));
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [7:0] d, input logic ordy);
    flush         = fl;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // fields: flush, in_valid, in_data, out_ready | in_ready, out_valid, out_data, count, afull, aempty
    tv.push_back('{0,1,8'h11,0, 1,0,8'h00,3'd0,0,1});
    tv.push_back('{0,1,8'h12,0, 1,1,8'h11,3'd1,0,1});
    tv.push_back('{0,1,8'h13,0, 1,1,8'h11,3'd2,0,0});
    tv.push_back('{0,1,8'h14,0, 1,1,8'h11,3'd3,0,0});
    tv.push_back('{0,1,8'h15,0, 1,1,8'h11,3'd4,1,0});
    tv.push_back('{0,1,8'h16,0, 0,1,8'h11,3'd5,1,0});
    tv.push_back('{0,0,8'h00,1, 0,1,8'h11,3'd5,1,0});
    tv.push_back('{0,0,8'h00,1, 1,1,8'h12,3'd4,1,0});
    tv.push_back('{0,0,8'h00,1, 1,1,8'h13,3'd3,0,0});
    tv.push_back('{0,1,8'h21,0, 1,1,8'h14,3'd2,0,0});
    tv.push_back('{0,1,8'h22,0, 1,1,8'h14,3'd3,0,0});
    tv.push_back('{0,1,8'h23,0, 1,1,8'h14,3'd4,1,0});
    tv.push_back('{0,0,8'h00,1, 0,1,8'h14,3'd5,1,0});
    tv.push_back('{0,0,8'h00,1, 1,1,8'h15,3'd4,1,0});
    tv.push_back('{0,0,8'h00,1, 1,1,8'h21,3'd3,0,0});
    tv.push_back('{0,0,8'h00,1, 1,1,8'h22,3'd2,0,0});
    tv.push_back('{0,0,8'h00,1, 1,1,8'h23,3'd1,0,1});
    tv.push_back('{0,0,8'h00,0, 1,0,8'h00,3'd0,0,1});
    tv.push_back('{0,1,8'h31,0, 1,0,8'h00,3'd0,0,1});
    tv.push_back('{0,1,8'h32,0, 1,1,8'h31,3'd1,0,1});
    tv.push_back('{0,1,8'h33,0, 1,1,8'h31,3'd2,0,0});
    tv.push_back('{0,1,8'h34,0, 1,1,8'h31,3'd3,0,0});
    tv.push_back('{0,1,8'h35,0, 1,1,8'h31,3'd4,1,0});
    tv.push_back('{0,1,8'h36,1, 0,1,8'h31,3'd5,1,0});
    tv.push_back('{0,1,8'h37,1, 1,1,8'h32,3'd4,1,0});
    tv.push_back('{0,0,8'h00,1, 1,1,8'h33,3'd4,1,0});
    tv.push_back('{1,1,8'h40,1, 0,0,8'h00,3'd3,0,0});
    tv.push_back('{0,0,8'h00,0, 1,0,8'h00,3'd0,0,1});

    reset = 1'b1;
    drive(0, 0, 8'h00, 0);
    #1;
    chk_outputs("reset", 1, 0, 8'h00, 3'd0, 0, 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tv.size(); i++) begin
      vec_t v;
      v = tv[i];
`ifdef RV_SYNC_FIFO_BYPASS_EN
      // While empty the input word is visible on the output side directly.
      if (v.e_cnt == 3'd0 && !v.fl) begin
        v.e_ov = v.iv;
        v.e_od = v.d;
      end
`endif
      drive(v.fl, v.iv, v.d, v.ordy);
      @(negedge clk);
      chk_outputs($sformatf("vec%0d", i), v.e_ir, v.e_ov, v.e_od, v.e_cnt, v.e_af, v.e_ae);
      @(posedge clk);
      #1;
    end

    // Empty FIFO offered a word with the consumer ready.
    drive(0, 1, 8'hA5, 1);
    @(negedge clk);
`ifdef RV_SYNC_FIFO_BYPASS_EN
    chk("bypass.out_valid", 32'(bus.out_valid), 32'd1);
    chk("bypass.out_data",  32'(bus.out_data),  32'hA5);
    chk("bypass.count",     32'(bus.count),     32'd0);
`else
    chk("nobypass.out_valid", 32'(bus.out_valid), 32'd0);
    chk("nobypass.count",     32'(bus.count),     32'd0);
`endif
    @(posedge clk);
    #1;
    drive(0, 0, 8'h00, 0);
    @(negedge clk);
`ifdef RV_SYNC_FIFO_BYPASS_EN
    chk("bypass_after.count",     32'(bus.count),     32'd0);
    chk("bypass_after.out_valid", 32'(bus.out_valid), 32'd0);
`else
    chk("nobypass_after.out_valid", 32'(bus.out_valid), 32'd1);
    chk("nobypass_after.out_data",  32'(bus.out_data),  32'hA5);
    chk("nobypass_after.count",     32'(bus.count),     32'd1);
    @(posedge clk);
    #1;
    drive(0, 0, 8'h00, 1);
    @(posedge clk);
    #1;
    drive(0, 0, 8'h00, 0);
    @(negedge clk);
    chk("nobypass_drain.count", 32'(bus.count), 32'd0);
`endif
    @(posedge clk);
    #1;

    // Reset asserted between edges with three words queued.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 8'(8'h51 + i), 0);
      @(posedge clk);
      #1;
    end
    drive(0, 0, 8'h00, 0);
    #1;
    chk("midop_pre.count", 32'(bus.count), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk_outputs("midop_reset", 1, 0, 8'h00, 3'd0, 0, 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    drive(0, 1, 8'h66, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 8'h00, 0);
    @(negedge clk);
    chk_outputs("midop_after", 1, 1, 8'h66, 3'd1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_sync_fifo.md
RV_SYNC_FIFO -- requirements
Module: rv_sync_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of entries, any integer >= 2, power of two not required.
REQ-002 SHALL have parameter WIDTH, default 32: data bits per entry, >= 1.
REQ-003 SHALL have parameter AFULL_THRESH, default DEPTH-1: almost_full asserts at count >= this value.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 1: almost_empty asserts at count <= this value.
REQ-005 SHALL have port clk  in  1  single clock; all state on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port flush  in  1  synchronous discard of all contents.
REQ-008 SHALL have port in_valid  in  1  producer offers in_data.
REQ-009 SHALL have port in_ready  out  1  FIFO can accept a word.
REQ-010 SHALL have port in_data  in  WIDTH  write data.
REQ-011 SHALL have port out_valid  out  1  out_data holds a valid word.
REQ-012 SHALL have port out_ready  in  1  consumer takes out_data.
REQ-013 SHALL have port out_data  out  WIDTH  head-of-queue data, first-word-fall-through.
REQ-014 SHALL have port count  out  $clog2(DEPTH+1)  current occupancy.
REQ-015 SHALL have ports almost_full and almost_empty  out  1 each  threshold flags.

Function
REQ-016 SHALL accept a write when in_valid && in_ready, and a read when out_valid && out_ready, both on the same clk edge.
REQ-017 SHALL drive in_ready = (count != DEPTH) && !flush; in_ready SHALL NOT depend on out_ready (no write-through-when-full).
REQ-018 SHALL drive out_valid = (count != 0) && !flush; out_data = entry at read pointer, else all zeros.
REQ-019 SHALL wrap read/write pointers from DEPTH-1 to 0 explicitly (no power-of-two modulo).
REQ-020 SHALL update count: +1 write only, -1 read only, unchanged on simultaneous write+read.
REQ-021 SHALL deliver a word written at edge N on out_valid/out_data after edge N (latency 1 cycle, empty FIFO, bypass disabled).
REQ-022 SHALL, when flush=1, ignore in_valid/out_ready that cycle and set pointers and count to 0 at the next edge; flush has priority over all transfers.
REQ-023 SHALL derive almost_full and almost_empty combinationally from the count register.
REQ-024 SHALL fail elaboration if DEPTH < 2, AFULL_THRESH not in 1..DEPTH, or AEMPTY_THRESH not in 0..DEPTH-1.

Reset
REQ-025 SHALL, on reset=1, asynchronously clear pointers and count: in_ready=1, out_valid=0, out_data=0, count=0, almost_empty=1, almost_full=0.
REQ-026 SHALL leave storage array contents unreset; a reset mid-operation discards all queued words.

Configuration
REQ-027 SHALL support macro RV_SYNC_FIFO_BYPASS_EN.
REQ-028 With RV_SYNC_FIFO_BYPASS_EN defined: when count==0 and !flush, out_valid=in_valid and out_data=in_data; if out_ready also 1, the word is consumed same cycle, not stored, count stays 0.
REQ-029 Without RV_SYNC_FIFO_BYPASS_EN: no combinational path from in_* to out_*; REQ-021 latency applies.

Structure
REQ-030 SHALL place in package rv_sync_fifo_pkg: function returning count width for a DEPTH, and the default-threshold constants.
REQ-031 SHALL instantiate storage as sub-module rv_sync_fifo_mem (DEPTH x WIDTH, 1 write port, 1 async read port, no reset).

Verification (DEPTH=5, WIDTH=8, AFULL_THRESH=4, AEMPTY_THRESH=1)
REQ-032 Fill: after reset, write 0x11..0x15, out_ready=0 -> almost_full=1 at count=4, in_ready=0 at count=5, 6th write 0x16 not accepted.
REQ-033 Drain/wrap: 3 reads, 3 writes 0x21..0x23, drain all -> order 0x14,0x15,0x21,0x22,0x23; count returns to 0; almost_empty=1 at count<=1.
REQ-034 Simultaneous at full: count=5, in_valid=1, out_ready=1 -> only read, count=4; next cycle both -> count stays 4.
REQ-035 Flush: count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, no word transferred.
REQ-036 Bypass: empty, in_data=0xA5, in_valid=out_ready=1 -> macro on: out_valid=1, out_data=0xA5 same cycle, count=0; macro off: out_valid=0, next cycle out_data=0xA5, count=1.
REQ-037 Reset mid-op: count=3, assert reset between edges -> outputs immediately per REQ-025; after release, first write appears unchanged.
